// File: rtl/nco_sel_sequencer.sv
// -----------------------------------------------------------------------------
// nco_sel_sequencer
//
// Waveform-select sequencer sitting in front of the NCO. Select requests come
// in over a valid/ready handshake and wait in a small circular FIFO. The head
// entry is applied to o_signal_out only when no hold is in progress. Every
// change of o_signal_out is followed by a hold of HOLD_CYCLES-1 cycles, so two
// consecutive changes are always at least HOLD_CYCLES edges apart. A queued
// select equal to the current output is dropped without starting a hold.
//
// Ports
//   i_clk          system clock, everything on posedge
//   i_reset        synchronous active-high reset
//   i_req_valid    request present
//   o_req_ready    request accepted at the next edge if i_req_valid is high
//   i_req_sel      requested waveform select
//   i_flush        empties the request queue at the next edge
//   o_signal_out   registered select driven to the NCO
//   o_sel_update   one-cycle pulse in the first cycle of a new o_signal_out
//   o_hold_active  high while a select change is being held
//   o_fifo_count   number of queued requests
//
// FSM states
//   state   | meaning
//   ST_IDLE | no hold running, head of queue may be applied
//   ST_HOLD | o_signal_out frozen, r_hold_cnt counting down to 1
// -----------------------------------------------------------------------------
module nco_sel_sequencer #(
  parameter int SELECT_WIDTH = 3,
  parameter int HOLD_CYCLES  = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [SELECT_WIDTH-1:0]          i_req_sel,
  input  logic                             i_flush,
  output logic [SELECT_WIDTH-1:0]          o_signal_out,
  output logic                             o_sel_update,
  output logic                             o_hold_active,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SELECT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [HW-1:0]           r_hold_cnt;
  logic [SELECT_WIDTH-1:0] r_signal_out;
  logic                    r_sel_update;
  logic                    r_hold_active;

  logic                    w_push;
  logic                    w_pop;
  logic [SELECT_WIDTH-1:0] w_head;

  // Ready is based only on the current count, so a full queue refuses a
  // request even in a cycle where the head is being popped.
  assign o_req_ready = !i_reset && !i_flush && (r_count < CW'(FIFO_DEPTH));
  assign w_push      = i_req_valid && o_req_ready;
  // A flush wins over the pop scheduled for the same edge.
  assign w_pop       = (r_state == ST_IDLE) && (r_hold_cnt == '0) &&
                       (r_count != '0) && !i_flush;
  assign w_head      = r_mem[r_rd_ptr];

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_req_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_signal_out  <= '0;
      r_sel_update  <= 1'b0;
      r_hold_active <= 1'b0;
    end else begin
      r_sel_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A popped head equal to the current output is simply consumed.
          if (w_pop && (w_head != r_signal_out)) begin
            r_signal_out  <= w_head;
            r_sel_update  <= 1'b1;
            r_hold_cnt    <= HW'(HOLD_CYCLES - 1);
            r_hold_active <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HW'(1)) begin
            r_hold_cnt    <= '0;
            r_hold_active <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_signal_out  = r_signal_out;
  assign o_sel_update  = r_sel_update;
  assign o_hold_active = r_hold_active;
  assign o_fifo_count  = r_count;

endmodule
